// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller.
// Op codes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SEQ = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd10;
  localparam logic [3:0] OP_LDI = 4'd11;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small general register file for the command controller.
// Two async read ports, one sync write port, sync clear.
module alu_regfile #(
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [7:0]    rdata1,
  output logic [7:0]    rdata2
);

  logic [7:0] regs [NREGS];

  // Clear on reset, otherwise single write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-driven initiator for the external 8-bit ALU.
// Accepts one command at a time and returns a response.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [7:0]    cmd_imm,
  input  logic          cmd_use_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err,
  output logic          alu_en,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_op,
  input  logic [7:0]    alu_out,
  input  logic [3:0]    alu_flags,
  output logic          busy
);

  state_t        state;
  logic [AW-1:0] rd_q;
  logic [7:0]    rf_a;
  logic [7:0]    rf_b;
  logic [7:0]    opb;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  alu_regfile #(
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (cmd_rs1),
    .raddr2 (cmd_rs2),
    .rdata1 (rf_a),
    .rdata2 (rf_b)
  );

  assign opb = cmd_use_imm ? cmd_imm : rf_b;

  // LDI writes at accept; ALU results write in CAPTURE.
  always_comb begin
    we    = 1'b0;
    waddr = rd_q;
    wdata = alu_out;
    if (state == ST_IDLE && cmd_valid
        && cmd_op == OP_LDI) begin
      we    = 1'b1;
      waddr = cmd_rd;
      wdata = cmd_imm;
    end else if (state == ST_CAPTURE) begin
      we = 1'b1;
    end
  end

  // Command FSM with registered ALU drive and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_q      <= '0;
      rsp_data  <= 8'h00;
      rsp_flags <= 4'h0;
      rsp_err   <= 1'b0;
      alu_en    <= 1'b0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 4'h0;
    end else begin
      alu_en <= 1'b0;
      alu_a  <= 8'h00;
      alu_b  <= 8'h00;
      alu_op <= 4'h0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rd_q <= cmd_rd;
            unique case (1'b1)
              is_alu_op(cmd_op): begin
                alu_en <= 1'b1;
                alu_a  <= rf_a;
                alu_b  <= opb;
                alu_op <= cmd_op;
                state  <= ST_ISSUE;
              end
              (cmd_op == OP_LDI): begin
                rsp_data <= cmd_imm;
                rsp_err  <= 1'b0;
                state    <= ST_RESP;
              end
              default: begin
                rsp_data <= 8'h00;
                rsp_err  <= 1'b1;
                state    <= ST_RESP;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags;
          rsp_err   <= 1'b0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl with a behavioural ALU attached.
// Random and directed commands against a register model.
module tb_alu_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs1;
  logic [1:0] cmd_rs2;
  logic [7:0] cmd_imm;
  logic       cmd_use_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic       alu_en;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_regs [4];
  logic [3:0] ref_flags;

  alu_cmd_ctrl #(.NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_imm     (cmd_imm),
    .cmd_use_imm (cmd_use_imm),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .alu_en      (alu_en),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {N,Z,V,C, result}.
  function automatic logic [11:0] alu_fn(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    r = 8'h00;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        r = a - b;
        c = a < b;
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: begin
        p = {8'h00, a} * {8'h00, b};
        r = p[7:0];
        c = |p[15:8];
      end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~a;
      4'd7: begin
        r = {a[6:0], 1'b0};
        c = a[7];
      end
      4'd8: begin
        r = {1'b0, a[7:1]};
        c = a[0];
      end
      4'd9:  r = {7'h00, a == b};
      4'd10: r = {7'h00, $signed(a) < $signed(b)};
      default: r = 8'h00;
    endcase
    return {r[7], r == 8'h00, v, c, r};
  endfunction

  // The attached ALU: registered result, updated on alu_en.
  always @(posedge clk) begin
    if (rst) begin
      alu_out   <= 8'h00;
      alu_flags <= 4'h0;
    end else if (alu_en) begin
      {alu_flags, alu_out} <= alu_fn(alu_op, alu_a, alu_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_flags = 4'h0;
  endtask

  // Drive one command, follow it to its response, check it.
  task automatic run_cmd(
    input logic [3:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs1,
    input logic [1:0] rs2,
    input logic [7:0] imm,
    input logic       ui,
    input int         hold,
    input logic       pend
  );
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  ed;
    logic [3:0]  ef;
    logic        ee;
    logic [11:0] res;
    int          el;
    int          ecnt;
    int          lat;
    int          en_n;
    int          en_c;
    a = ref_regs[rs1];
    b = ui ? imm : ref_regs[rs2];
    res = 12'h000;
    if (op <= 4'd10) begin
      res = alu_fn(op, a, b);
      ed = res[7:0];
      ef = res[11:8];
      ee = 1'b0;
      el = 3;
      ecnt = 1;
    end else if (op == 4'd11) begin
      ed = imm;
      ef = ref_flags;
      ee = 1'b0;
      el = 1;
      ecnt = 0;
    end else begin
      ed = 8'h00;
      ef = ref_flags;
      ee = 1'b1;
      el = 1;
      ecnt = 0;
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_rd      = rd;
    cmd_rs1     = rs1;
    cmd_rs2     = rs2;
    cmd_imm     = imm;
    cmd_use_imm = ui;
    lat  = 0;
    en_n = 0;
    en_c = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      n_cmp++;
      if (alu_en === 1'b1) begin
        en_n++;
        if (en_c == 0) en_c = c;
        if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin
          n_bad++;
          $display("FAIL alu_drive: got a=%h b=%h op=%h want a=%h b=%h op=%h",
                   alu_a, alu_b, alu_op, a, b, op);
        end
      end else if ({alu_a, alu_b, alu_op} !== 20'h0) begin
        n_bad++;
        $display("FAIL alu_idle_zero: got a=%h b=%h op=%h want 0",
                 alu_a, alu_b, alu_op);
      end
      if (rsp_valid === 1'b1) lat = c;
    end
    n_cmp++;
    if (lat != el) begin
      n_bad++;
      $display("FAIL rsp_latency op=%0d: got %0d want %0d", op, lat, el);
    end
    n_cmp++;
    if (en_n != ecnt || en_c != ecnt) begin
      n_bad++;
      $display("FAIL alu_en_pulse op=%0d: got count %0d at %0d want %0d",
               op, en_n, en_c, ecnt);
    end
    n_cmp++;
    if ({rsp_data, rsp_flags, rsp_err} !== {ed, ef, ee}) begin
      n_bad++;
      $display("FAIL rsp op=%0d: got d=%h f=%b e=%b want d=%h f=%b e=%b",
               op, rsp_data, rsp_flags, rsp_err, ed, ef, ee);
    end
    if (pend) begin
      cmd_valid   = 1'b1;
      cmd_op      = 4'd11;
      cmd_rd      = 2'd0;
      cmd_imm     = 8'hAA;
      cmd_use_imm = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, cmd_ready, busy, alu_en} !== 4'b1010
          || {rsp_data, rsp_flags, rsp_err} !== {ed, ef, ee}) begin
        n_bad++;
        $display("FAIL hold_stable: got v=%b r=%b bz=%b en=%b d=%h f=%b e=%b want d=%h f=%b e=%b",
                 rsp_valid, cmd_ready, busy, alu_en, rsp_data, rsp_flags,
                 rsp_err, ed, ef, ee);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL after_handshake: got v=%b r=%b bz=%b want 0 1 0",
               rsp_valid, cmd_ready, busy);
    end
    if (op <= 4'd10) begin
      ref_regs[rd] = ed;
      ref_flags    = ef;
    end else if (op == 4'd11) begin
      ref_regs[rd] = imm;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    rsp_ready   = 1'b0;
    cmd_op      = 4'h0;
    cmd_rd      = 2'd0;
    cmd_rs1     = 2'd0;
    cmd_rs2     = 2'd0;
    cmd_imm     = 8'h00;
    cmd_use_imm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_cmp++;
    if ({cmd_ready, rsp_valid, busy, alu_en} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got r=%b v=%b bz=%b en=%b want 1 0 0 0",
               cmd_ready, rsp_valid, busy, alu_en);
    end
    n_cmp++;
    if ({rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_op} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_data: got d=%h f=%b e=%b a=%h b=%h op=%h want 0",
               rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_op);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    run_cmd(4'd11, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 0, 1'b0);
    run_cmd(4'd11, 2'd2, 2'd0, 2'd0, 8'h01, 1'b1, 0, 1'b0);
    run_cmd(4'd0, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({ref_regs[3], ref_flags} !== {8'h80, 4'b1010}) begin
      n_bad++;
      $display("FAIL add_spec: got %h %b want 80 1010",
               ref_regs[3], ref_flags);
    end
  endtask

  task automatic test_sub_borrow();
    run_cmd(4'd11, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 0, 1'b0);
    run_cmd(4'd11, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 0, 1'b0);
    run_cmd(4'd1, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic test_and_imm();
    run_cmd(4'd11, 2'd0, 2'd0, 2'd0, 8'hF3, 1'b1, 0, 1'b0);
    run_cmd(4'd11, 2'd2, 2'd0, 2'd0, 8'h55, 1'b1, 0, 1'b0);
    run_cmd(4'd3, 2'd1, 2'd0, 2'd2, 8'h0F, 1'b1, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_cmd(4'd12, 2'd3, 2'd0, 2'd1, 8'h5A, 1'b0, 1, 1'b0);
    run_cmd(4'd15, 2'd0, 2'd1, 2'd2, 8'hFF, 1'b1, 0, 1'b0);
    run_cmd(4'd4, 2'd3, 2'd3, 2'd0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd(4'd0, 2'd1, 2'd0, 2'd1, 8'h00, 1'b0, 5, 1'b1);
    run_cmd(4'd4, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_capture();
    run_cmd(4'd11, 2'd3, 2'd0, 2'd0, 8'h55, 1'b1, 0, 1'b0);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = 4'd0;
    cmd_rd      = 2'd3;
    cmd_rs1     = 2'd1;
    cmd_rs2     = 2'd2;
    cmd_use_imm = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({cmd_ready, rsp_valid, busy, alu_en} !== 4'b1000
        || {rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_op} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_capture: got r=%b v=%b bz=%b en=%b d=%h f=%b e=%b want idle zeros",
               cmd_ready, rsp_valid, busy, alu_en, rsp_data, rsp_flags,
               rsp_err);
    end
    run_cmd(4'd4, 2'd0, 2'd3, 2'd3, 8'h00, 1'b0, 0, 1'b0);
    n_cmp++;
    if ({ref_regs[0], ref_flags} !== {8'h00, 4'b0100}) begin
      n_bad++;
      $display("FAIL or_after_reset: got %h %b want 00 0100",
               ref_regs[0], ref_flags);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_cmd(4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 2),
              1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_borrow();
    test_and_imm();
    test_illegal();
    test_backpressure();
    test_reset_capture();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-driven initiator for the 8-bit ALU: accepts register-level operation commands over a valid/ready port, reads operands from a small local register file, and issues single-cycle enable pulses to the ALU. It captures the registered ALU result and flags, writes the result back, and returns a response with data, flags and error status. It sits between a host/sequencer and the ALU. The ALU instance itself is external and is wired to this block's `alu_*` ports.

## Interface
- `NREGS`, default 4: number of 8-bit general registers. Power of two, ≥2. `AW = $clog2(NREGS)` is derived.

Ports:
- `clk` in 1: single clock for the block and the attached ALU.
- `rst` in 1: reset, synchronous, active-high. The ALU's active-low reset is driven from `~rst` at integration.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_op` in 4: operation code. 0–10 are ALU ops (ADD, SUB, MUL, AND, OR, XOR, NOT, SHL, SHR, SEQ, SLT); 11 is LDI; 12–15 are illegal.
- `cmd_rd` in AW: destination register.
- `cmd_rs1` in AW: source register for operand A.
- `cmd_rs2` in AW: source register for operand B.
- `cmd_imm` in 8: immediate value.
- `cmd_use_imm` in 1: when 1, operand B is `cmd_imm` instead of `reg[rs2]`.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_data` out 8: the value written to rd (0 on error).
- `rsp_flags` out 4: {N,Z,V,C} captured from the ALU.
- `rsp_err` out 1: the command was illegal.
- `alu_en` out 1: one-cycle issue pulse to the ALU.
- `alu_a` out 8: ALU operand A.
- `alu_b` out 8: ALU operand B.
- `alu_op` out 4: ALU operation code.
- `alu_out` in 8: registered ALU result.
- `alu_flags` in 4: registered ALU flags.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - `cmd_ready=1`.
  - On `cmd_valid`, latch op, rd, and operands. Operand A = `reg[rs1]`. Operand B = `use_imm ? imm : reg[rs2]`.
  - op 0–10 → ISSUE.
  - op 11 (LDI): `reg[rd] <= imm`; `rsp_data=imm`; flag register unchanged → RESP.
  - op 12–15: `rsp_err=1`, `rsp_data=0`, no writeback, no ALU issue → RESP.
- **ISSUE**: `alu_en=1` for exactly this cycle with `alu_a`/`alu_b`/`alu_op` driven from the latched values → CAPTURE.
- **CAPTURE**: sample `alu_out`/`alu_flags` (the ALU updated at the ISSUE edge). Write `reg[rd] <= alu_out`, set the flag register to `alu_flags`, set `rsp_data=alu_out` and `rsp_err=0` → RESP.
- **RESP**: `rsp_valid=1`. Hold `rsp_data`/`rsp_flags`/`rsp_err` stable until `rsp_ready`. On handshake → IDLE.
- `rsp_flags` always shows the flag register. LDI and error responses report the last ALU flags.
- Operand values are latched at accept. `rd==rs1` and `rs1==rs2` are legal; the write occurs only in CAPTURE.
- `alu_a`, `alu_b` and `alu_op` are 0 whenever `alu_en=0`.

## Timing
- Reset values:
  - FSM = IDLE; all registers = 0; flag register = 0.
  - `cmd_ready=1`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_flags=0`, `rsp_err=0`.
  - `alu_en=0`, `alu_a=0`, `alu_b=0`, `alu_op=0`.
  - `busy=0`.
- Latency for an ALU op accepted at cycle T:
  - `alu_en` high at T+1.
  - Capture at T+2.
  - `rsp_valid` from T+3.
- Latency for LDI or an illegal op accepted at T: `rsp_valid` from T+1.
- Throughput: at most one command in flight. `cmd_ready=0` from T+1 until the cycle after the response handshake, so the earliest next accept is the cycle after `rsp_valid & rsp_ready`.
- Back-pressure: `rsp_ready=0` holds RESP indefinitely with outputs stable. No further `alu_en` pulses are issued.
- `cmd_valid` outside IDLE is ignored. The command is not consumed.
- Reset in any state, including CAPTURE, wins. The in-flight ALU result is discarded and no writeback occurs.

## Structure
- Package `alu_pkg` holds:
  - op-code localparams (`OP_ADD`…`OP_SLT`=4'd10, `OP_LDI`=4'd11);
  - flag bit indices (`FLAG_C`=0, `FLAG_V`=1, `FLAG_Z`=2, `FLAG_N`=3);
  - the FSM state enum.
- One natural sub-module: `alu_regfile`. It has NREGS×8 registers, two combinational read ports, one synchronous write port, and synchronous clear on `rst`.
- FSM, operand latch and response registers live in `alu_cmd_ctrl`.

## Test plan
- Reset, then `LDI r1,0x7F`; `LDI r2,0x01`; `ADD r3,r1,r2` → `rsp_data=0x80`, `rsp_flags=4'b1010`. `alu_en` pulses exactly once, 1 cycle after accept. `rsp_valid` rises 3 cycles after accept.
- `LDI r0,0x00`; `LDI r1,0x01`; `SUB r2,r0,r1` → `rsp_data=0xFF`, `rsp_flags=4'b1001`.
- `AND r1,r0,imm` with `cmd_use_imm=1`, `r0=0xF3`, `imm=0x0F` → `rsp_data=0x03`, `rsp_flags=4'b0000`. `reg[rs2]` is ignored.
- `cmd_op=4'b1100` → `rsp_err=1`, `rsp_data=0`, `alu_en` never high, register file unchanged, flags equal to the previous response's flags.
- `rsp_ready` held low for 5 cycles in RESP → response outputs stable, `cmd_ready=0`, a presented command is not accepted until the cycle after the handshake.
- Assert `rst` during CAPTURE of `ADD r3` → next cycle all outputs at reset values, `r3` reads 0 via a subsequent `OR r0,r3,r3` with result 0x00 and Z=1.
